// File: rtl/dsp_dot_acc.sv
// dsp_dot_acc: signed, bias-seeded multiply-accumulate engine.
// Computes P = C + sum(A[i] * (D[i] +/- B[i])) over a programmable number of
// beats through a 3-stage pipeline: input register, pre-add/multiply register,
// then the accumulator. Valid/ready handshakes on both the beat and result sides.
// Optional build macro: DSP_ACC_SAT_EN makes the accumulator saturate and
// drives a sticky OVF flag; without it the accumulator wraps and OVF stays 0.
module dsp_dot_acc #(
    parameter int A_W   = 18,
    parameter int B_W   = 18,
    parameter int ACC_W = 48,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [ACC_W-1:0] c,
    input  logic             preadd,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [B_W-1:0]   d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] p,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int PROD_W = A_W + B_W + 1;
    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               preadd_q;
    logic               sub_q;
    logic               drain_cnt;

    logic [A_W-1:0]     a_r;
    logic [B_W-1:0]     b_r;
    logic [B_W-1:0]     d_r;
    logic               i_vld;
    logic [PROD_W-1:0]  m_r;
    logic               m_vld;

    logic [ACC_W-1:0]   acc;
    logic               ovf_q;

    logic [B_W:0]       pre;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum_ext;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf_hit;

    logic               beat_take;

    assign beat_take = in_valid & in_ready;

    // Pre-adder: operand is D+/-B or sign-extended B, one bit wider so nothing is lost.
    always_comb begin
        pre = {b_r[B_W-1], b_r};
        if (preadd_q) begin
            if (sub_q) begin
                pre = {d_r[B_W-1], d_r} - {b_r[B_W-1], b_r};
            end else begin
                pre = {d_r[B_W-1], d_r} + {b_r[B_W-1], b_r};
            end
        end
    end

    assign prod = {{(B_W+1){a_r[A_W-1]}}, a_r} * {{A_W{pre[B_W]}}, pre};

    // Accumulate one extra bit wide so overflow is visible, then wrap or clamp.
    always_comb begin
        sum_ext  = {acc[ACC_W-1], acc} + {{(ACC_W-A_W-B_W){m_r[PROD_W-1]}}, m_r};
        acc_next = sum_ext[ACC_W-1:0];
        ovf_hit  = 1'b0;
`ifdef DSP_ACC_SAT_EN
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            ovf_hit  = 1'b1;
            acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    // Input and multiply stages; bubbles travel as cleared valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            d_r   <= '0;
            i_vld <= 1'b0;
            m_r   <= '0;
            m_vld <= 1'b0;
        end else begin
            i_vld <= beat_take;
            if (beat_take) begin
                a_r <= a;
                b_r <= b;
                d_r <= d;
            end
            m_vld <= i_vld;
            if (i_vld) begin
                m_r <= prod;
            end
        end
    end

    // Run control, beat counting, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            preadd_q  <= 1'b0;
            sub_q     <= 1'b0;
            drain_cnt <= 1'b0;
            acc       <= '0;
            ovf_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (m_vld && state != IDLE) begin
                acc <= acc_next;
                if (ovf_hit) begin
                    ovf_q <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        preadd_q  <= preadd;
                        sub_q     <= sub;
                        acc       <= c;
                        ovf_q     <= 1'b0;
                        cnt       <= '0;
                        drain_cnt <= 1'b0;
                        busy      <= 1'b1;
                        if (len != '0) begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                RUN: begin
                    if (beat_take) begin
                        cnt <= cnt + ONE;
                        if (cnt == len_q - ONE) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p   = acc;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_dsp_dot_acc.sv
// tb_dsp_dot_acc: randomized and directed bench for dsp_dot_acc, with a
// reference model that evaluates the dot product using plain integer math.
module tb_dsp_dot_acc;

    localparam int A_W   = 18;
    localparam int B_W   = 18;
    localparam int ACC_W = 48;
    localparam int LEN_W = 8;

    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [ACC_W-1:0] c;
    logic             preadd;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   a;
    logic [B_W-1:0]   b;
    logic [B_W-1:0]   d;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] p;
    logic             ovf;
    logic             busy;

    int tests_run;
    int fail_count;

    longint exp_acc;
    bit     exp_ovf;
    bit     m_pre;
    bit     m_sub;

    int qa[$];
    int qb[$];
    int qd[$];

    dsp_dot_acc #(
        .A_W  (A_W),
        .B_W  (B_W),
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .c        (c),
        .preadd   (preadd),
        .sub      (sub),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic longint wrapAcc(input longint v);
        longint m;
        m = v & ((longint'(1) <<< ACC_W) - 1);
        if (((m >>> (ACC_W-1)) & 1) != 0) m = m - (longint'(1) <<< ACC_W);
        return m;
    endfunction

    function automatic int randOp(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w-1));
    endfunction

    function automatic void modelBeat(input int va, input int vb, input int vd);
        longint op;
        longint exact;
        op    = m_pre ? (m_sub ? longint'(vd) - vb : longint'(vd) + vb) : longint'(vb);
        exact = exp_acc + longint'(va) * op;
`ifdef DSP_ACC_SAT_EN
        if (exact > ACC_MAX) begin
            exp_acc = ACC_MAX;
            exp_ovf = 1'b1;
        end else if (exact < ACC_MIN) begin
            exp_acc = ACC_MIN;
            exp_ovf = 1'b1;
        end else begin
            exp_acc = exact;
        end
`else
        exp_acc = wrapAcc(exact);
`endif
    endfunction

    task automatic startRun(input int n, input longint cv, input bit pa, input bit sb);
        @(negedge clk);
        start  = 1'b1;
        len    = LEN_W'(n);
        c      = ACC_W'(cv);
        preadd = pa;
        sub    = sb;
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_acc = cv;
        exp_ovf = 1'b0;
        m_pre   = pa;
        m_sub   = sb;
    endtask

    task automatic applyStimulus(input int n, input int gap, input bit rand_gap);
        int va, vb, vd, idle;
        for (int i = 0; i < n; i++) begin
            idle = (i == 0) ? 0 : gap;
            if (rand_gap) idle = int'($urandom_range(0, 2));
            for (int g = 0; g < idle; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                checkOutput("in_ready_gap", 64'(in_ready), 1);
                @(posedge clk);
            end
            va = (qa.size() > 0) ? qa.pop_front() : randOp(A_W);
            vb = (qb.size() > 0) ? qb.pop_front() : randOp(B_W);
            vd = (qd.size() > 0) ? qd.pop_front() : randOp(B_W);
            @(negedge clk);
            checkOutput("in_ready_run", 64'(in_ready), 1);
            in_valid = 1'b1;
            a = A_W'(va);
            b = B_W'(vb);
            d = B_W'(vd);
            modelBeat(va, vb, vd);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic checkDrain();
        @(negedge clk);
        checkOutput("drain1_out_valid", 64'(out_valid), 0);
        checkOutput("drain1_in_ready", 64'(in_ready), 0);
        checkOutput("drain1_busy", 64'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("drain2_out_valid", 64'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("hold_out_valid", 64'(out_valid), 1);
        checkOutput("hold_p", $signed(p), exp_acc);
        checkOutput("hold_ovf", 64'(ovf), 64'(exp_ovf));
        checkOutput("hold_in_ready", 64'(in_ready), 0);
    endtask

    task automatic holdAndRelease(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 64'(out_valid), 1);
            checkOutput("bp_p", $signed(p), exp_acc);
            checkOutput("bp_in_ready", 64'(in_ready), 0);
            checkOutput("bp_busy", 64'(busy), 1);
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            len       = LEN_W'($urandom_range(0, 5));
            in_valid  = 1'b1;
            a         = A_W'(randOp(A_W));
            b         = B_W'(randOp(B_W));
        end
        @(negedge clk);
        checkOutput("rel_pre_out_valid", 64'(out_valid), 1);
        checkOutput("rel_pre_p", $signed(p), exp_acc);
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("rel_out_valid", 64'(out_valid), 0);
        checkOutput("rel_busy", 64'(busy), 0);
        checkOutput("rel_in_ready", 64'(in_ready), 0);
    endtask

    task automatic fullRun(input int n, input longint cv, input bit pa, input bit sb,
                           input int gap, input bit rand_gap, input int hold);
        startRun(n, cv, pa, sb);
        applyStimulus(n, gap, rand_gap);
        checkDrain();
        holdAndRelease(hold);
    endtask

    initial begin
        tests_run  = 0;
        fail_count = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        c          = '0;
        preadd     = 1'b0;
        sub        = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        d          = '0;
        out_ready  = 1'b0;
        exp_acc    = 0;
        exp_ovf    = 1'b0;
        m_pre      = 1'b0;
        m_sub      = 1'b0;

        #12;
        checkOutput("rst_p", $signed(p), 0);
        checkOutput("rst_out_valid", 64'(out_valid), 0);
        checkOutput("rst_in_ready", 64'(in_ready), 0);
        checkOutput("rst_busy", 64'(busy), 0);
        checkOutput("rst_ovf", 64'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // plain dot product
        qa = '{1, 2, 3, 4};
        qb = '{2, 2, 2, 2};
        qd = '{0, 0, 0, 0};
        startRun(4, 0, 1'b0, 1'b0);
        applyStimulus(4, 0, 1'b0);
        checkDrain();
        checkOutput("plain_p20", $signed(p), 20);
        holdAndRelease(0);

        // pre-add subtract and add with bias
        qa = '{-2}; qb = '{3}; qd = '{10};
        startRun(1, 100, 1'b1, 1'b1);
        applyStimulus(1, 0, 1'b0);
        checkDrain();
        checkOutput("preadd_sub_p86", $signed(p), 86);
        holdAndRelease(0);
        qa = '{-2}; qb = '{3}; qd = '{10};
        startRun(1, 100, 1'b1, 1'b0);
        applyStimulus(1, 0, 1'b0);
        checkDrain();
        checkOutput("preadd_add_p74", $signed(p), 74);
        holdAndRelease(0);

        // bubbles
        qa = '{5, 5, 5}; qb = '{5, 5, 5}; qd = '{0, 0, 0};
        startRun(3, 0, 1'b0, 1'b0);
        applyStimulus(3, 2, 1'b0);
        checkDrain();
        checkOutput("bubble_p75", $signed(p), 75);
        holdAndRelease(0);

        // zero length, then backpressure in HOLD
        startRun(0, -5, 1'b0, 1'b0);
        checkDrain();
        checkOutput("len0_p", $signed(p), -5);
        holdAndRelease(6);

        // overflow at default widths
        qa = '{-131072}; qb = '{-131072}; qd = '{0};
        startRun(1, ACC_MAX, 1'b0, 1'b0);
        applyStimulus(1, 0, 1'b0);
        checkDrain();
`ifdef DSP_ACC_SAT_EN
        checkOutput("ovf_p", $signed(p), ACC_MAX);
        checkOutput("ovf_flag", 64'(ovf), 1);
`else
        checkOutput("ovf_p", $signed(p), ACC_MIN + (longint'(1) <<< 34) - 1);
        checkOutput("ovf_flag", 64'(ovf), 0);
`endif
        holdAndRelease(1);

        // reset mid-run
        startRun(4, 1234, 1'b0, 1'b0);
        applyStimulus(2, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_p", $signed(p), 0);
        checkOutput("mid_rst_busy", 64'(busy), 0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 0);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 0);
        checkOutput("mid_rst_ovf", 64'(ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        qa = '{1}; qb = '{1}; qd = '{0};
        startRun(1, 0, 1'b0, 1'b0);
        applyStimulus(1, 0, 1'b0);
        checkDrain();
        checkOutput("post_rst_p1", $signed(p), 1);
        holdAndRelease(0);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            longint cv;
            cv = wrapAcc({$urandom, $urandom});
            if ($urandom_range(0, 1) == 0) cv = longint'(randOp(20));
            fullRun(int'($urandom_range(0, 6)), cv, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule

// File: doc/dsp_dot_acc.md
# dsp_dot_acc

Parametrised, signed multiply-accumulate engine: the next-generation DSP slice in this codebase. It computes a bias-seeded dot product P = C + Σ A[i]·(D[i] ± B[i]) over a programmable number of beats. It uses a 3-stage pipeline (input register, pre-add/multiply register, accumulator) with valid/ready handshakes on both the input and result sides. It sits behind stream sources (filters, correlators) where the fixed-width DSP slice and its free-running OPMODE control are insufficient.

## Interface
- A_W, 18, signed width of A
- B_W, 18, signed width of B and D
- ACC_W, 48, accumulator/P width; must be ≥ A_W+B_W+1
- LEN_W, 8, width of beat-count field
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle run request; sampled only in IDLE
- LEN  in  LEN_W  beats in the run, sampled with START
- C  in  ACC_W  signed bias, sampled with START
- PREADD  in  1  1: multiplier operand is D±B; 0: operand is B; sampled with START
- SUB  in  1  1: pre-adder computes D−B; 0: D+B; sampled with START
- IN_VALID  in  1  beat present on A/B/D
- IN_READY  out  1  engine accepts a beat this cycle
- A  in  A_W  signed multiplicand
- B  in  B_W  signed operand
- D  in  B_W  signed pre-adder operand
- OUT_VALID  out  1  P holds a finished result
- OUT_READY  in  1  consumer takes the result
- P  out  ACC_W  signed accumulator / result
- OVF  out  1  sticky overflow flag for the current run
- BUSY  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, HOLD. Reset state is IDLE.
- Reset values: P=0, OVF=0, OUT_VALID=0, IN_READY=0, BUSY=0; pipeline valids cleared; beat counter=0.
- IDLE, START=1:
  - Latch LEN, PREADD, SUB; load acc←sign-extended C; clear OVF and the counter.
  - Go to RUN if LEN≠0, else DRAIN.
- RUN:
  - IN_READY=1. A beat is accepted when IN_VALID&IN_READY; the counter increments on each accepted beat.
  - Accepting the beat with count==LEN−1 moves to DRAIN; IN_READY is 0 from the next cycle.
- DRAIN: lasts exactly 2 cycles, flushing the pipeline, then goes to HOLD.
- HOLD:
  - OUT_VALID=1; P and OVF frozen.
  - OUT_READY=1 → IDLE; OUT_VALID drops after that edge.
- START outside IDLE is ignored. IN_VALID outside RUN is ignored.
- Arithmetic, all two's complement signed:
  - Pre-add result is B_W+1 bits with no truncation.
  - Product is A_W+B_W+1 bits, sign-extended to ACC_W before accumulation.
  - When PREADD=0, B is sign-extended to B_W+1 bits.
- Accumulator adds the M-stage value only when the M-stage valid bit is set, so bubbles (IN_VALID low in RUN) are free.
- RSTN low at any time returns to IDLE with reset values asynchronously; a partial run is discarded.

## Timing
- Beat accepted at edge e:
  - Input regs load at e.
  - M reg loads at e+1.
  - Accumulator updates at e+2.
- Last beat accepted at edge e → DRAIN after e, HOLD and OUT_VALID=1 after e+2. P is final at that point. Latency is 3 edges.
- LEN=0: START at edge s → OUT_VALID=1 after s+2 with P=C.
- Throughput is one beat per cycle in RUN.
- OUT_VALID&OUT_READY at edge h → IDLE after h. The next START is accepted at h+1 at the earliest.
- P is observable every cycle as the running accumulator. It is valid only while OUT_VALID=1.

## Configuration
- DSP_ACC_SAT_EN defined:
  - An accumulate whose exact sum exceeds the ACC_W signed range clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1).
  - OVF sets and stays set until the next START.
- Not defined:
  - Accumulator wraps modulo 2^ACC_W.
  - OVF is tied 0.

## Test plan
- Plain dot product: LEN=4, C=0, PREADD=0, A=1,2,3,4, B=2 on consecutive cycles → OUT_VALID 3 edges after last beat, P=20, OVF=0.
- Pre-add subtract with bias: LEN=1, C=100, PREADD=1, SUB=1, D=10, B=3, A=−2 → P=86. Repeat with SUB=0 → P=74.
- Bubbles and zero length: LEN=3 with IN_VALID gaps of 2 cycles between beats A=B=5 → P=75. Separately, LEN=0, C=−5 → P=−5, OUT_VALID 2 edges after START.
- Backpressure: hold OUT_READY=0 for 6 cycles in HOLD while pulsing START and IN_VALID → P, OUT_VALID stable, IN_READY=0, no new run. OUT_READY=1 → IDLE next edge.
- Overflow, default widths: C=2^47−1, LEN=1, A=B=−131072, PREADD=0 → with DSP_ACC_SAT_EN: P=2^47−1, OVF=1. Without it: P wraps to −2^47+2^34−1, OVF=0.
- Reset mid-run: drop RSTN during RUN after 2 of 4 beats → outputs at reset values immediately. A new run of LEN=1, A=B=1, C=0 afterwards gives P=1.
